io_bus_initiator: RTL and testbench

IO_BUS_INITIATOR -- requirements
Module: io_bus_initiator

---
 rtl/io_bus_initiator_pkg.sv | 24 ++
 rtl/io_bus_initiator_if.sv | 45 ++++
 rtl/io_bus_initiator.sv | 149 ++++++++++++++
 tb/tb_io_bus_initiator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_initiator_pkg.sv
// ============================================================
// Package : io_bus_initiator_pkg
// Shared widths, defaults and state encodings for the I/O bus initiator.
// Rev     : 1.0
// ============================================================
`default_nettype none

package io_bus_initiator_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 8;

  localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT = 22'h100000;
  localparam int unsigned       TIMEOUT_DEFAULT = 255;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage : io_bus_initiator_pkg

`default_nettype wire

// File: rtl/io_bus_initiator_if.sv
// ============================================================
// Interface : io_bus_initiator_if
// CPU-side request/ack bus and I/O-side request/ack bus of the initiator.
// Rev       : 1.0
// ============================================================
`default_nettype none

interface io_bus_initiator_if;
  import io_bus_initiator_pkg::*;

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rd_req;
  logic              cpu_wr_req;
  logic [DATA_W-1:0] cpu_wr_data;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              cpu_rd_ack;
  logic              cpu_wr_ack;
  logic              cpu_err;

  logic [IDX_W-1:0]  io_rd_addr;
  logic              io_rd_req;
  logic [DATA_W-1:0] io_rd_data;
  logic              io_rd_ack;
  logic [IDX_W-1:0]  io_wr_addr;
  logic              io_wr_req;
  logic [DATA_W-1:0] io_wr_data;
  logic              io_wr_ack;

  modport master (
    input  cpu_addr, cpu_rd_req, cpu_wr_req, cpu_wr_data,
    output cpu_rd_data, cpu_rd_ack, cpu_wr_ack, cpu_err,
    output io_rd_addr, io_rd_req, io_wr_addr, io_wr_req, io_wr_data,
    input  io_rd_data, io_rd_ack, io_wr_ack
  );

  modport slave (
    output cpu_addr, cpu_rd_req, cpu_wr_req, cpu_wr_data,
    input  cpu_rd_data, cpu_rd_ack, cpu_wr_ack, cpu_err,
    input  io_rd_addr, io_rd_req, io_wr_addr, io_wr_req, io_wr_data,
    output io_rd_data, io_rd_ack, io_wr_ack
  );

endinterface : io_bus_initiator_if

`default_nettype wire

// File: rtl/io_bus_initiator.sv
// ============================================================
// Module : io_bus_initiator
// Bridges CPU word accesses into a 16-register I/O window with ack timeout.
// Rev    : 1.0
// ============================================================
`default_nettype none

module io_bus_initiator
  import io_bus_initiator_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEFAULT,
  parameter int unsigned       TIMEOUT = TIMEOUT_DEFAULT
) (
  input  wire logic          clk,
  input  wire logic          rst,
  io_bus_initiator_if.master bus
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  logic [1:0]        state_q,       state_d;
  logic [CNT_W-1:0]  cnt_q,         cnt_d;
  logic              is_wr_q,       is_wr_d;
  logic              in_win_q,      in_win_d;
  logic [IDX_W-1:0]  idx_q,         idx_d;
  logic [DATA_W-1:0] wr_data_q,     wr_data_d;
  logic              io_rd_req_q,   io_rd_req_d;
  logic              io_wr_req_q,   io_wr_req_d;
  logic              cpu_rd_ack_q,  cpu_rd_ack_d;
  logic              cpu_wr_ack_q,  cpu_wr_ack_d;
  logic              cpu_err_q,     cpu_err_d;
  logic [DATA_W-1:0] cpu_rd_data_q, cpu_rd_data_d;

  logic             w_accept;
  logic             w_in_win;
  logic             w_ack_match;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;
  logic             w_done;
  logic             w_ok;

  assign w_accept    = (state_q == ST_IDLE) && (bus.cpu_wr_req || bus.cpu_rd_req);
  assign w_in_win    = bus.cpu_addr[ADDR_W-1:IDX_W] == IO_BASE[ADDR_W-1:IDX_W];
  // Only the ack matching the outstanding direction may complete it.
  assign w_ack_match = is_wr_q ? bus.io_wr_ack : bus.io_rd_ack;
  assign w_cnt_inc   = cnt_q + 1'b1;
  assign w_timeout   = (w_cnt_inc == C_TIMEOUT);
  // An out-of-window access spends one REQ cycle with no I/O request, then errors.
  assign w_done      = !in_win_q || w_ack_match || w_timeout;
  assign w_ok        = in_win_q && w_ack_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      is_wr_q       <= 1'b0;
      in_win_q      <= 1'b0;
      idx_q         <= '0;
      wr_data_q     <= '0;
      io_rd_req_q   <= 1'b0;
      io_wr_req_q   <= 1'b0;
      cpu_rd_ack_q  <= 1'b0;
      cpu_wr_ack_q  <= 1'b0;
      cpu_err_q     <= 1'b0;
      cpu_rd_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_wr_q       <= is_wr_d;
      in_win_q      <= in_win_d;
      idx_q         <= idx_d;
      wr_data_q     <= wr_data_d;
      io_rd_req_q   <= io_rd_req_d;
      io_wr_req_q   <= io_wr_req_d;
      cpu_rd_ack_q  <= cpu_rd_ack_d;
      cpu_wr_ack_q  <= cpu_wr_ack_d;
      cpu_err_q     <= cpu_err_d;
      cpu_rd_data_q <= cpu_rd_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept) state_d = ST_REQ;
      ST_REQ:  if (w_done)   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    is_wr_d       = is_wr_q;
    in_win_d      = in_win_q;
    idx_d         = idx_q;
    wr_data_d     = wr_data_q;
    io_rd_req_d   = 1'b0;
    io_wr_req_d   = 1'b0;
    cpu_rd_ack_d  = 1'b0;
    cpu_wr_ack_d  = 1'b0;
    cpu_err_d     = 1'b0;
    cpu_rd_data_d = cpu_rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          cnt_d       = '0;
          is_wr_d     = bus.cpu_wr_req;
          in_win_d    = w_in_win;
          idx_d       = bus.cpu_addr[IDX_W-1:0];
          wr_data_d   = bus.cpu_wr_data;
          io_wr_req_d = w_in_win && bus.cpu_wr_req;
          io_rd_req_d = w_in_win && !bus.cpu_wr_req;
        end
      end
      ST_REQ: begin
        if (w_done) begin
          cpu_wr_ack_d = is_wr_q;
          cpu_rd_ack_d = !is_wr_q;
          cpu_err_d    = !w_ok;
          if (!w_ok) begin
            cpu_rd_data_d = '0;
          end else if (!is_wr_q) begin
            cpu_rd_data_d = bus.io_rd_data;
          end
        end else begin
          cnt_d       = w_cnt_inc;
          io_rd_req_d = io_rd_req_q;
          io_wr_req_d = io_wr_req_q;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.cpu_rd_data = cpu_rd_data_q;
  assign bus.cpu_rd_ack  = cpu_rd_ack_q;
  assign bus.cpu_wr_ack  = cpu_wr_ack_q;
  assign bus.cpu_err     = cpu_err_q;
  assign bus.io_rd_addr  = idx_q;
  assign bus.io_rd_req   = io_rd_req_q;
  assign bus.io_wr_addr  = idx_q;
  assign bus.io_wr_req   = io_wr_req_q;
  assign bus.io_wr_data  = wr_data_q;

endmodule : io_bus_initiator

`default_nettype wire

// File: tb/tb_io_bus_initiator.sv
// ============================================================
// Module : tb_io_bus_initiator
// Directed self-checking bench for io_bus_initiator (TIMEOUT = 4).
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_io_bus_initiator;
  import io_bus_initiator_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        ack_en;
  logic [63:0] resp_data;
  logic        mon_en = 1'b0;

  io_bus_initiator_if bus ();

  io_bus_initiator #(
    .IO_BASE (22'h100000),
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Registered responder: acks one cycle after it sees a request, so it
  // also returns a trailing ack one cycle after the request drops.
  always @(posedge clk) begin
    bus.io_rd_ack  <= ack_en && bus.io_rd_req;
    bus.io_wr_ack  <= ack_en && bus.io_wr_req;
    bus.io_rd_data <= (ack_en && bus.io_rd_req) ? resp_data : 64'd0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("io_req_exclusive", 64'(bus.io_rd_req & bus.io_wr_req), 64'd0);
      check("err_outside_ack", 64'(bus.cpu_err & ~(bus.cpu_rd_ack | bus.cpu_wr_ack)), 64'd0);
    end
  end

  initial begin
    rst              = 1'b1;
    ack_en           = 1'b0;
    resp_data        = 64'd0;
    bus.cpu_addr     = '0;
    bus.cpu_rd_req   = 1'b0;
    bus.cpu_wr_req   = 1'b0;
    bus.cpu_wr_data  = '0;
    repeat (3) step();
    check("rst_rd_ack",  64'(bus.cpu_rd_ack), 64'd0);
    check("rst_wr_ack",  64'(bus.cpu_wr_ack), 64'd0);
    check("rst_err",     64'(bus.cpu_err),    64'd0);
    check("rst_io_rd",   64'(bus.io_rd_req),  64'd0);
    check("rst_io_wr",   64'(bus.io_wr_req),  64'd0);
    check("rst_rd_data", bus.cpu_rd_data,     64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    // In-window read, responder data 5A
    ack_en = 1'b1; resp_data = 64'h5A;
    bus.cpu_addr = 22'h100009; bus.cpu_rd_req = 1'b1;
    step();
    check("rd_c1_io_req",  64'(bus.io_rd_req),  64'd1);
    check("rd_c1_io_addr", 64'(bus.io_rd_addr), 64'd9);
    check("rd_c1_ack",     64'(bus.cpu_rd_ack), 64'd0);
    step();
    check("rd_c2_io_req",  64'(bus.io_rd_req),  64'd1);
    check("rd_c2_ack",     64'(bus.cpu_rd_ack), 64'd0);
    step();
    check("rd_c3_ack",     64'(bus.cpu_rd_ack), 64'd1);
    check("rd_c3_data",    bus.cpu_rd_data,     64'h5A);
    check("rd_c3_err",     64'(bus.cpu_err),    64'd0);
    check("rd_c3_io_req",  64'(bus.io_rd_req),  64'd0);
    bus.cpu_rd_req = 1'b0;
    step();
    check("rd_c4_ack",     64'(bus.cpu_rd_ack), 64'd0);
    check("rd_c4_hold",    bus.cpu_rd_data,     64'h5A);

    // In-window write with trailing ack
    bus.cpu_addr = 22'h100008; bus.cpu_wr_data = 64'hA5; bus.cpu_wr_req = 1'b1;
    step();
    check("wr_c1_io_req",  64'(bus.io_wr_req),  64'd1);
    check("wr_c1_io_addr", 64'(bus.io_wr_addr), 64'd8);
    check("wr_c1_io_data", bus.io_wr_data,      64'hA5);
    step();
    check("wr_c2_io_req",  64'(bus.io_wr_req),  64'd1);
    check("wr_c2_ack",     64'(bus.cpu_wr_ack), 64'd0);
    step();
    check("wr_c3_ack",     64'(bus.cpu_wr_ack), 64'd1);
    check("wr_c3_err",     64'(bus.cpu_err),    64'd0);
    check("wr_c3_io_req",  64'(bus.io_wr_req),  64'd0);
    check("wr_c3_rd_ack",  64'(bus.cpu_rd_ack), 64'd0);
    bus.cpu_wr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wr_tail_io_req", 64'(bus.io_wr_req),  64'd0);
      check("wr_tail_ack",    64'(bus.cpu_wr_ack), 64'd0);
    end

    // Read timeout with no responder
    ack_en = 1'b0;
    bus.cpu_addr = 22'h100002; bus.cpu_rd_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("to_io_req", 64'(bus.io_rd_req),  64'd1);
      check("to_early",  64'(bus.cpu_rd_ack), 64'd0);
    end
    step();
    check("to_io_drop", 64'(bus.io_rd_req),  64'd0);
    check("to_ack",     64'(bus.cpu_rd_ack), 64'd1);
    check("to_err",     64'(bus.cpu_err),    64'd1);
    check("to_data",    bus.cpu_rd_data,     64'd0);
    bus.cpu_rd_req = 1'b0;
    step();
    check("to_after",   64'(bus.cpu_rd_ack), 64'd0);

    // Simultaneous write and read: write first, then read
    ack_en = 1'b1; resp_data = 64'hC3;
    bus.cpu_addr = 22'h100003; bus.cpu_wr_data = 64'h77;
    bus.cpu_wr_req = 1'b1; bus.cpu_rd_req = 1'b1;
    step();
    check("both_c1_wr",   64'(bus.io_wr_req),  64'd1);
    check("both_c1_rd",   64'(bus.io_rd_req),  64'd0);
    check("both_c1_addr", 64'(bus.io_wr_addr), 64'd3);
    step();
    step();
    check("both_c3_wrack", 64'(bus.cpu_wr_ack), 64'd1);
    check("both_c3_rdack", 64'(bus.cpu_rd_ack), 64'd0);
    bus.cpu_wr_req = 1'b0;
    step();
    check("both_c4_rd",   64'(bus.io_rd_req),  64'd0);
    step();
    check("both_c5_rd",   64'(bus.io_rd_req),  64'd1);
    check("both_c5_wr",   64'(bus.io_wr_req),  64'd0);
    check("both_c5_addr", 64'(bus.io_rd_addr), 64'd3);
    step();
    step();
    check("both_c7_rdack", 64'(bus.cpu_rd_ack), 64'd1);
    check("both_c7_data",  bus.cpu_rd_data,     64'hC3);
    check("both_c7_err",   64'(bus.cpu_err),    64'd0);
    bus.cpu_rd_req = 1'b0;
    step();

    // Out-of-window read
    bus.cpu_addr = 22'h000010; bus.cpu_rd_req = 1'b1;
    step();
    check("oow_c1_io_req", 64'(bus.io_rd_req),  64'd0);
    check("oow_c1_ack",    64'(bus.cpu_rd_ack), 64'd0);
    step();
    check("oow_c2_ack",    64'(bus.cpu_rd_ack), 64'd1);
    check("oow_c2_err",    64'(bus.cpu_err),    64'd1);
    check("oow_c2_data",   bus.cpu_rd_data,     64'd0);
    check("oow_c2_io_req", 64'(bus.io_rd_req),  64'd0);
    bus.cpu_rd_req = 1'b0;
    step();
    check("oow_c3_ack",    64'(bus.cpu_rd_ack), 64'd0);

    // Reset during an outstanding write; late ack must be ignored
    ack_en = 1'b1;
    bus.cpu_addr = 22'h100005; bus.cpu_wr_data = 64'hDEAD; bus.cpu_wr_req = 1'b1;
    step();
    check("rstw_c1_io_req", 64'(bus.io_wr_req), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; bus.cpu_wr_req = 1'b0;
    check("rstw_io_req",  64'(bus.io_wr_req),  64'd0);
    check("rstw_io_data", bus.io_wr_data,      64'd0);
    check("rstw_io_addr", 64'(bus.io_wr_addr), 64'd0);
    check("rstw_wr_ack",  64'(bus.cpu_wr_ack), 64'd0);
    check("rstw_err",     64'(bus.cpu_err),    64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstw_late_ack", 64'(bus.cpu_wr_ack), 64'd0);
      check("rstw_late_req", 64'(bus.io_wr_req),  64'd0);
      check("rstw_late_rd",  64'(bus.io_rd_req),  64'd0);
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_io_bus_initiator

`default_nettype wire
